// File: rtl/imem_fetch_buffered.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_buffered
// Purpose  : Word-organised, byte-lane-writable instruction memory. A clear
//            engine fills it with NOP after reset, a loader port writes it,
//            and the fetch stage reads it over a valid/ready handshake with
//            a one-cycle registered response and fault reporting.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_buffered #(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_be,
    output logic              ld_err,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [1:0]        rsp_fault
);

    localparam int                CNT_W      = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] c_DEPTH_A  = ADDR_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(DEPTH_WORDS - 1);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    localparam logic [1:0] c_FAULT_OK  = 2'b00;
    localparam logic [1:0] c_FAULT_MIS = 2'b01;
    localparam logic [1:0] c_FAULT_OOR = 2'b10;

    // Storage array; contents are initialised by the clear engine, not reset
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_err_q, ld_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_instr_q, rsp_instr_d;
    logic [1:0]       rsp_fault_q, rsp_fault_d;

    logic             w_clr_we;
    logic             w_ready_st;
    logic             w_ld_mis, w_ld_oor, w_ld_we;
    logic             w_req_mis, w_req_oor, w_accept;
    logic [CNT_W-1:0] w_ld_idx, w_req_idx;
    logic             w_wr_en;
    logic [CNT_W-1:0] w_wr_idx;
    logic [31:0]      w_wr_data;
    logic [3:0]       w_wr_be;

    // Address decode: the range check uses the full word index (no wrap),
    // only the low CNT_W index bits address the array once in range
    assign w_ld_mis  = (ld_addr[1:0] != 2'b00);
    assign w_ld_oor  = ({2'b00, ld_addr[ADDR_W-1:2]} >= c_DEPTH_A);
    assign w_ld_idx  = ld_addr[CNT_W+1:2];
    assign w_req_mis = (req_addr[1:0] != 2'b00);
    assign w_req_oor = ({2'b00, req_addr[ADDR_W-1:2]} >= c_DEPTH_A);
    assign w_req_idx = req_addr[CNT_W+1:2];

    assign w_ld_we   = ld_en && w_ready_st && !w_ld_mis && !w_ld_oor;
    assign req_ready = w_ready_st && (!rsp_valid_q || rsp_ready);
    assign w_accept  = req_valid && req_ready;

    // FSM state register and clear counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: walk every word once, then stay READY until reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == c_ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_CNT_LAST) begin
                state_d = c_ST_READY;
                cnt_d   = cnt_q;
            end
        end
    end

    // FSM outputs: clear write strobe and ready indication
    always_comb begin
        w_clr_we   = (state_q == c_ST_CLEAR);
        w_ready_st = (state_q == c_ST_READY);
        init_done  = (state_q == c_ST_READY);
    end

    // Single write port shared by the clear engine and the loader
    always_comb begin
        w_wr_en   = w_clr_we || w_ld_we;
        w_wr_idx  = w_clr_we ? cnt_q : w_ld_idx;
        w_wr_data = w_clr_we ? NOP_WORD : ld_data;
        w_wr_be   = w_clr_we ? 4'hF : ld_be;
    end

    // Array write with per-byte-lane enables
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) begin
                    mem_q[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Response next state: capture on accept (old array contents, so a
    // same-cycle loader write is not seen), retire when consumed, else hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_fault_d = rsp_fault_q;
        ld_err_d    = ld_en && (!w_ready_st || w_ld_mis || w_ld_oor);
        if (w_accept) begin
            rsp_valid_d = 1'b1;
            if (w_req_mis) begin
                rsp_fault_d = c_FAULT_MIS;
                rsp_instr_d = NOP_WORD;
            end else if (w_req_oor) begin
                rsp_fault_d = c_FAULT_OOR;
                rsp_instr_d = NOP_WORD;
            end else begin
                rsp_fault_d = c_FAULT_OK;
                rsp_instr_d = mem_q[w_req_idx];
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response and loader-error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= NOP_WORD;
            rsp_fault_q <= c_FAULT_OK;
            ld_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_fault_q <= rsp_fault_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_fault = rsp_fault_q;
    assign ld_err    = ld_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_buffered
// Purpose  : Self-checking bench for imem_fetch_buffered; a reference memory
//            model predicts each response when a request is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_buffered;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_done;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [3:0]  ld_be = '0;
    logic        ld_err;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_ready = 1'b0;
    logic        exp_ld_err  = 1'b0;
    logic [33:0] sb_q [$];

    imem_fetch_buffered #(
        .ADDR_W(32), .DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
        .ld_err(ld_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [33:0] model_fetch(input logic [31:0] a);
        logic [31:0] widx;
        widx = a >> 2;
        if (a[1:0] != 2'b00)  return {2'b01, NOP};
        if (widx >= DEPTH)     return {2'b10, NOP};
        return {2'b00, model_mem[widx[5:0]]};
    endfunction

    // Scoreboard monitor, sampling mid-cycle where inputs and outputs are stable
    always @(negedge clk) begin
        logic [33:0] exp_rsp;
        logic [31:0] widx;
        if (reset) begin
            sb_q.delete();
            exp_ld_err = 1'b0;
        end else begin
            n_checks++;
            if (ld_err !== exp_ld_err) begin
                n_fail++;
                $display("FAIL sb_ld_err: got %b expected %b at %0t", ld_err, exp_ld_err, $time);
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rsp: got %h/%b expected no response", rsp_instr, rsp_fault);
                end else begin
                    exp_rsp = sb_q.pop_front();
                    if ({rsp_fault, rsp_instr} !== exp_rsp) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got fault %b instr %h expected fault %b instr %h",
                                 rsp_fault, rsp_instr, exp_rsp[33:32], exp_rsp[31:0]);
                    end
                end
            end
            if (req_valid && req_ready) sb_q.push_back(model_fetch(req_addr));
            exp_ld_err = 1'b0;
            if (ld_en) begin
                widx = ld_addr >> 2;
                if (!model_ready || ld_addr[1:0] != 2'b00 || widx >= DEPTH) begin
                    exp_ld_err = 1'b1;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (ld_be[b]) model_mem[widx[5:0]][8*b +: 8] = ld_data[8*b +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        model_ready = 1'b0;
    endtask

    task automatic wait_init();
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) begin
                n_checks++;
                if (init_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL init_early: got %b expected 0 at cycle %0d", init_done, i);
                end
            end
        end
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done: got %b expected 1 at cycle %0d", init_done, DEPTH);
        end
        model_ready = 1'b1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ld_en = 1'b1; ld_addr = a; ld_data = d; ld_be = be;
        tick();
        ld_en = 1'b0; ld_be = '0;
    endtask

    task automatic fetch(input logic [31:0] a);
        int  n;
        logic acc;
        req_valid = 1'b1; req_addr = a; n = 0;
        do begin
            acc = req_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        req_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL fetch_timeout: addr %h not accepted within %0d cycles", a, n);
        end
    endtask

    task automatic test_reset();
        model_clear();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({init_done, req_ready, rsp_valid, rsp_fault, ld_err} !== 6'b0 || rsp_instr !== NOP) begin
            n_fail++;
            $display("FAIL reset_vals: got done=%b rdy=%b vld=%b flt=%b err=%b instr=%h expected all 0, instr %h",
                     init_done, req_ready, rsp_valid, rsp_fault, ld_err, rsp_instr, NOP);
        end
        reset = 1'b0;
        // edge 1..64 of the clear; a loader write in the middle must be refused
        for (int i = 1; i <= 10; i++) tick();
        ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'hDEAD_BEEF; ld_be = 4'hF;
        tick();
        ld_en = 1'b0; ld_be = '0;
        n_checks++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_ld_err: got %b expected 1", ld_err);
        end
        for (int i = 12; i < DEPTH; i++) tick();
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL init_early: got %b expected 0 at cycle %0d", init_done, DEPTH - 1);
        end
        tick();
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done: got %b expected 1 at cycle %0d", init_done, DEPTH);
        end
        model_ready = 1'b1;
        rsp_ready = 1'b1;
        fetch(32'h0);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_instr !== NOP || rsp_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL boot_fetch: got vld=%b instr=%h flt=%b expected 1 %h 00", rsp_valid, rsp_instr, rsp_fault, NOP);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        words[0] = 32'hFFC4_A303; words[1] = 32'h0064_A423;
        words[2] = 32'h0062_E233; words[3] = 32'hFE42_0AE3;
        for (int i = 0; i < 4; i++) load(32'(i * 4), words[i], 4'hF);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(i * 4);
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready: got %b expected 1 at request %0d", req_ready, i);
            end
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_instr !== words[i]) begin
                n_fail++;
                $display("FAIL b2b_rsp: got vld=%b instr=%h expected 1 %h", rsp_valid, rsp_instr, words[i]);
            end
        end
        req_valid = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_retire: got rsp_valid %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'h1234_5678; ld_be = 4'hF;
            end
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_instr !== 32'h0064_A423 || rsp_fault !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_hold: got vld=%b rdy=%b instr=%h flt=%b expected 1 0 0064a423 00",
                         rsp_valid, req_ready, rsp_instr, rsp_fault);
            end
            tick();
            ld_en = 1'b0; ld_be = '0;
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got req_ready %b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0062_E233) begin
            n_fail++;
            $display("FAIL stall_next: got vld=%b instr=%h expected 1 0062e233", rsp_valid, rsp_instr);
        end
        tick();
        fetch(32'h4);
        n_checks++;
        if (rsp_instr !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL stall_write_visible: got %h expected 12345678", rsp_instr);
        end
        tick();
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        logic [1:0]  flts  [3];
        addrs[0] = 32'h6;   flts[0] = 2'b01;
        addrs[1] = 32'h100; flts[1] = 2'b10;
        addrs[2] = 32'hFFFF_FFFC; flts[2] = 2'b10;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i]);
            n_checks++;
            if (rsp_fault !== flts[i] || rsp_instr !== NOP) begin
                n_fail++;
                $display("FAIL fault_%0d: got flt=%b instr=%h expected %b %h", i, rsp_fault, rsp_instr, flts[i], NOP);
            end
        end
        load(32'h102, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_err_mis: got %b expected 1", ld_err);
        end
        load(32'h100, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_err_oor: got %b expected 1", ld_err);
        end
        load(32'h8, 32'hFFFF_FFFF, 4'b0000);
        n_checks++;
        if (ld_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_be0: got ld_err %b expected 0", ld_err);
        end
        fetch(32'h8);
        n_checks++;
        if (rsp_instr !== 32'h0062_E233 || rsp_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL ld_noop_unchanged: got %h/%b expected 0062e233/00", rsp_instr, rsp_fault);
        end
        tick();
    endtask

    task automatic test_read_before_write();
        rsp_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'h0000_00AB; ld_be = 4'b0001;
        req_valid = 1'b1; req_addr = 32'h0;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw_ready: got %b expected 1", req_ready);
        end
        tick();
        ld_en = 1'b0; ld_be = '0; req_valid = 1'b0;
        n_checks++;
        if (rsp_instr !== 32'hFFC4_A303) begin
            n_fail++;
            $display("FAIL rbw_old: got %h expected ffc4a303", rsp_instr);
        end
        tick();
        fetch(32'h0);
        n_checks++;
        if (rsp_instr !== 32'hFFC4_A3AB) begin
            n_fail++;
            $display("FAIL rbw_new: got %h expected ffc4a3ab", rsp_instr);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        model_clear();
        reset = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (init_done !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear_reset: got done=%b vld=%b expected 0 0", init_done, rsp_valid);
        end
        tick();
        reset = 1'b0;
        wait_init();
        rsp_ready = 1'b0;
        fetch(32'h8);
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_before_reset: got rsp_valid %b expected 1", rsp_valid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_instr !== NOP || req_ready !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_reset: got vld=%b instr=%h rdy=%b done=%b expected 0 %h 0 0",
                     rsp_valid, rsp_instr, req_ready, init_done, NOP);
        end
        tick();
        model_clear();
        reset = 1'b0;
        wait_init();
        rsp_ready = 1'b1;
        fetch(32'h0);
        n_checks++;
        if (rsp_instr !== NOP || rsp_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL recleared: got %h/%b expected %h/00", rsp_instr, rsp_fault, NOP);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_faults();
        test_read_before_write();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding responses expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
